// File: rtl/fsm_seq_monitor_if.sv
// fsm_seq_monitor_if: sample/clear inputs and status outputs
// of the ring-FSM monitor.
interface fsm_seq_monitor_if #(
  parameter int LAP_W = 8
);
  logic             clr;
  logic [2:0]       state_in;
  logic             dir;
  logic             step;
  logic             jump;
  logic             lap_pulse;
  logic [LAP_W-1:0] lap_cnt;
  logic             off_ring;
  logic             err_sticky;

  modport master (
    output clr, state_in,
    input  dir, step, jump, lap_pulse,
    input  lap_cnt, off_ring, err_sticky
  );

  modport slave (
    input  clr, state_in,
    output dir, step, jump, lap_pulse,
    output lap_cnt, off_ring, err_sticky
  );
endinterface

// File: rtl/fsm_seq_monitor.sv
// fsm_seq_monitor: classifies ring-FSM transitions, counts laps.
// Reverse laps counted only with FSM_SEQ_MON_REV_LAP_EN defined.
module fsm_seq_monitor #(
  parameter int LAP_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  fsm_seq_monitor_if.slave    mon
);

`ifdef FSM_SEQ_MON_REV_LAP_EN
  localparam bit REV_LAP = 1'b1;
`else
  localparam bit REV_LAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    C_HOLD, C_FWD, C_REV, C_REC, C_JMP
  } cls_e;

  typedef enum logic [1:0] {
    SEEK, AT0, RUN
  } trk_e;

  logic [2:0] prev;
  logic       prev_valid;
  trk_e       trk;
  logic       run_dir;
  logic [2:0] k;
  cls_e       cls;
  logic       lap_done;
  logic       lap_cnt_inc;
  logic [2:0] s;

  assign s = mon.state_in;

  function automatic logic is_off(input logic [2:0] v);
    return (v == 3'd2) || (v == 3'd4) || (v == 3'd5);
  endfunction

  function automatic logic [2:0] fwd_nxt(input logic [2:0] v);
    case (v)
      3'd0:    return 3'd6;
      3'd6:    return 3'd7;
      3'd7:    return 3'd3;
      3'd3:    return 3'd1;
      3'd1:    return 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] rev_nxt(input logic [2:0] v);
    case (v)
      3'd0:    return 3'd1;
      3'd1:    return 3'd3;
      3'd3:    return 3'd7;
      3'd7:    return 3'd6;
      3'd6:    return 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  // classify prev -> state_in
  always_comb begin
    cls = C_JMP;
    if (s == prev)
      cls = C_HOLD;
    else if (!is_off(prev) && !is_off(s)
             && s == fwd_nxt(prev))
      cls = C_FWD;
    else if (!is_off(prev) && !is_off(s)
             && s == rev_nxt(prev))
      cls = C_REV;
    else if (is_off(prev) && s == 3'd0)
      cls = C_REC;
  end

  // closing step of a lap in the tracked direction
  always_comb begin
    lap_done = 1'b0;
    if (prev_valid && trk == RUN && k == 3'd4) begin
      if (!run_dir && cls == C_FWD) lap_done = 1'b1;
      if (run_dir && cls == C_REV)  lap_done = 1'b1;
    end
    lap_cnt_inc = lap_done && (!run_dir || REV_LAP);
  end

  // sampler, classifier outputs and lap tracker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev           <= 3'd0;
      prev_valid     <= 1'b0;
      trk            <= SEEK;
      run_dir        <= 1'b0;
      k              <= 3'd0;
      mon.dir        <= 1'b0;
      mon.step       <= 1'b0;
      mon.jump       <= 1'b0;
      mon.lap_pulse  <= 1'b0;
      mon.lap_cnt    <= '0;
      mon.off_ring   <= 1'b0;
      mon.err_sticky <= 1'b0;
    end else begin
      prev          <= s;
      prev_valid    <= 1'b1;
      mon.off_ring  <= is_off(s);
      mon.step      <= 1'b0;
      mon.jump      <= 1'b0;
      mon.lap_pulse <= lap_cnt_inc;

      if (prev_valid) begin
        unique case (1'b1)
          cls == C_FWD: begin
            mon.step <= 1'b1;
            mon.dir  <= 1'b0;
          end
          cls == C_REV: begin
            mon.step <= 1'b1;
            mon.dir  <= 1'b1;
          end
          cls == C_JMP: mon.jump <= 1'b1;
          default: ;
        endcase
      end

      if (mon.clr)
        mon.err_sticky <= 1'b0;
      else if ((prev_valid && cls == C_JMP) || is_off(s))
        mon.err_sticky <= 1'b1;

      if (mon.clr)
        mon.lap_cnt <= '0;
      else if (lap_cnt_inc)
        mon.lap_cnt <= mon.lap_cnt + 1'b1;

      unique case (trk)
        SEEK: begin
          if (s == 3'd0) trk <= AT0;
        end
        AT0: begin
          if (prev_valid) begin
            if (cls == C_FWD || cls == C_REV) begin
              trk     <= RUN;
              run_dir <= (cls == C_REV);
              k       <= 3'd1;
            end else if (cls != C_HOLD) begin
              trk <= SEEK;
            end
          end
        end
        RUN: begin
          if (cls == C_HOLD) begin
            trk <= RUN;
          end else if ((!run_dir && cls == C_FWD)
                       || (run_dir && cls == C_REV)) begin
            if (k == 3'd4) trk <= AT0;
            else           k   <= k + 3'd1;
          end else begin
            trk <= (s == 3'd0) ? AT0 : SEEK;
          end
        end
        default: trk <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// tb_fsm_seq_monitor: directed checks of classification,
// lap counting, sticky error, clr priority and reset.
module tb_fsm_seq_monitor;

`ifdef FSM_SEQ_MON_REV_LAP_EN
  localparam int REV_EN = 1;
`else
  localparam int REV_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   steps;
  int   laps;

  fsm_seq_monitor_if #(.LAP_W(8)) bus ();

  fsm_seq_monitor #(.LAP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    bus.state_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dir"},  32'(bus.dir), 0);
    chk({tag, "_step"}, 32'(bus.step), 0);
    chk({tag, "_jump"}, 32'(bus.jump), 0);
    chk({tag, "_lapp"}, 32'(bus.lap_pulse), 0);
    chk({tag, "_lapc"}, 32'(bus.lap_cnt), 0);
    chk({tag, "_off"},  32'(bus.off_ring), 0);
    chk({tag, "_err"},  32'(bus.err_sticky), 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.clr      = 1'b0;
    bus.state_in = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;

    // forward lap 0,6,7,3,1,0
    drive(3'd0);
    chk("f0_step", 32'(bus.step), 0);
    chk("f0_off", 32'(bus.off_ring), 0);
    steps = 0;
    laps  = 0;
    drive(3'd6); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd7); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd3); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd1); steps += bus.step; laps += bus.lap_pulse;
    chk("f_dir", 32'(bus.dir), 0);
    chk("f_nolap_early", 32'(laps), 0);
    drive(3'd0); steps += bus.step;
    chk("f_lapp", 32'(bus.lap_pulse), 1);
    chk("f_steps", 32'(steps), 5);
    chk("f_lapc", 32'(bus.lap_cnt), 1);
    chk("f_jump", 32'(bus.jump), 0);
    chk("f_err", 32'(bus.err_sticky), 0);

    // reverse lap 0,1,3,7,6,0
    drive(3'd0);
    chk("r0_step", 32'(bus.step), 0);
    chk("r0_lapp", 32'(bus.lap_pulse), 0);
    steps = 0;
    laps  = 0;
    drive(3'd1); steps += bus.step; laps += bus.lap_pulse;
    chk("r_dir", 32'(bus.dir), 1);
    drive(3'd3); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd7); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd6); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd0); steps += bus.step; laps += bus.lap_pulse;
    chk("r_steps", 32'(steps), 5);
    chk("r_laps", 32'(laps), REV_EN);
    chk("r_lapc", 32'(bus.lap_cnt), 1 + REV_EN);
    chk("r_dir_end", 32'(bus.dir), 1);

    // jump and recovery 0,5,5,0
    drive(3'd0);
    drive(3'd5);
    chk("j5_jump", 32'(bus.jump), 1);
    chk("j5_off", 32'(bus.off_ring), 1);
    chk("j5_err", 32'(bus.err_sticky), 1);
    chk("j5_step", 32'(bus.step), 0);
    drive(3'd5);
    chk("j55_jump", 32'(bus.jump), 0);
    chk("j55_off", 32'(bus.off_ring), 1);
    drive(3'd0);
    chk("rec_jump", 32'(bus.jump), 0);
    chk("rec_off", 32'(bus.off_ring), 0);
    chk("rec_err", 32'(bus.err_sticky), 1);
    chk("rec_dir", 32'(bus.dir), 1);
    drive(3'd0);
    chk("hold_err", 32'(bus.err_sticky), 1);
    bus.clr = 1'b1;
    drive(3'd0);
    bus.clr = 1'b0;
    chk("clr_err", 32'(bus.err_sticky), 0);
    chk("clr_lapc", 32'(bus.lap_cnt), 0);
    drive(3'd0);
    chk("post_clr_err", 32'(bus.err_sticky), 0);

    // holds inside a lap 0,6,6,6,7,3,1,0
    steps = 0;
    laps  = 0;
    drive(3'd6); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd6); steps += bus.step; laps += bus.lap_pulse;
    chk("h_hold_step", 32'(bus.step), 0);
    drive(3'd6); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd7); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd3); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd1); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd0); steps += bus.step; laps += bus.lap_pulse;
    chk("h_steps", 32'(steps), 5);
    chk("h_laps", 32'(laps), 1);
    chk("h_lapc", 32'(bus.lap_cnt), 1);
    chk("h_dir", 32'(bus.dir), 0);

    // reversal mid-lap 0,6,7,6,0
    drive(3'd0);
    steps = 0;
    laps  = 0;
    drive(3'd6); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd7); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd6); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd0); steps += bus.step; laps += bus.lap_pulse;
    chk("v_steps", 32'(steps), 4);
    chk("v_laps", 32'(laps), 0);
    chk("v_dir", 32'(bus.dir), 1);
    chk("v_lapc", 32'(bus.lap_cnt), 1);
    chk("v_jump", 32'(bus.jump), 0);

    // clr in the closing-edge cycle
    drive(3'd6);
    drive(3'd7);
    drive(3'd3);
    drive(3'd1);
    bus.clr = 1'b1;
    drive(3'd0);
    bus.clr = 1'b0;
    chk("cc_lapp", 32'(bus.lap_pulse), 1);
    chk("cc_lapc", 32'(bus.lap_cnt), 0);
    chk("cc_step", 32'(bus.step), 1);

    // on-ring jump 0 -> 7
    drive(3'd0);
    drive(3'd7);
    chk("rj_jump", 32'(bus.jump), 1);
    chk("rj_off", 32'(bus.off_ring), 0);
    chk("rj_err", 32'(bus.err_sticky), 1);
    chk("rj_step", 32'(bus.step), 0);

    // reset mid-lap
    drive(3'd0);
    drive(3'd6);
    drive(3'd7);
    chk("pre_rst_step", 32'(bus.step), 1);
    rst = 1'b1;
    #1;
    chk_reset("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    steps = 0;
    laps  = 0;
    drive(3'd3);
    chk("pr_first_step", 32'(bus.step), 0);
    drive(3'd1); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd0); steps += bus.step; laps += bus.lap_pulse;
    chk("pr_nolap", 32'(laps), 0);
    drive(3'd6); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd7); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd3); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd1); steps += bus.step; laps += bus.lap_pulse;
    drive(3'd0); steps += bus.step; laps += bus.lap_pulse;
    chk("pr_steps", 32'(steps), 7);
    chk("pr_laps", 32'(laps), 1);
    chk("pr_lapc", 32'(bus.lap_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
